// File: rtl/psum_accumulator_if.sv
// Bundles the partial-sum input, control strobes and OFM output handshake of psum_accumulator.
// master = controller/PE side and OFM consumer; slave = the accumulator itself.
interface psum_accumulator_if #(
  parameter int PSUM_W     = 16,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                     start_conv;
  logic                     p_valid;
  logic                     last_chanel;
  logic signed [PSUM_W-1:0] psum_in;
  logic                     end_conv;
  logic signed [ACC_W-1:0]  ofm_data;
  logic                     ofm_valid;
  logic                     ofm_ready;
  logic [CNT_W-1:0]         fifo_count;
  logic                     ovf_err;
  logic                     acc_done;

  modport master (
    output start_conv, p_valid, last_chanel, psum_in, end_conv, ofm_ready,
    input  ofm_data, ofm_valid, fifo_count, ovf_err, acc_done
  );

  modport slave (
    input  start_conv, p_valid, last_chanel, psum_in, end_conv, ofm_ready,
    output ofm_data, ofm_valid, fifo_count, ovf_err, acc_done
  );
endinterface

// File: rtl/psum_accumulator.sv
// Per-position partial-sum accumulator bank feeding a show-ahead OFM FIFO.
// Optional macro PSUM_ACC_RELU_EN: clamp negative results to 0 when they are pushed.
module psum_accumulator #(
  parameter int TILE       = 16,
  parameter int PSUM_W     = 16,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  psum_accumulator_if.slave io_bus
);
  localparam int POS_W = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [POS_W-1:0]       LAST_POS = POS_W'(TILE - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                  r_state;
  logic [POS_W-1:0]        r_pos;
  logic [TILE-1:0]         r_ev;
  logic signed [ACC_W-1:0] r_acc [TILE];
  logic signed [ACC_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_ovf_err;
  logic                    r_acc_done;

  logic                    w_beat, w_push, w_pop, w_wr, w_full, w_empty;
  logic [TILE-1:0]         w_sel;
  logic signed [ACC_W-1:0] w_base, w_sum, w_push_val;
  logic [ACC_W:0]          w_sum_ext;

  // start_conv outranks any beat arriving in the same cycle
  assign w_beat  = io_bus.p_valid & ~io_bus.start_conv;
  assign w_push  = w_beat & io_bus.last_chanel;
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & io_bus.ofm_ready;
  // A pop frees the slot even when full, so push+pop together always succeeds
  assign w_wr    = w_push & (~w_full | w_pop);

  for (genvar gi = 0; gi < TILE; gi++) begin : g_sel
    assign w_sel[gi] = (r_pos == POS_W'(gi));
  end

  assign w_base    = r_ev[r_pos] ? r_acc[r_pos] : '0;
  assign w_sum_ext = {w_base[ACC_W-1], w_base}
                   + {{(ACC_W+1-PSUM_W){io_bus.psum_in[PSUM_W-1]}}, io_bus.psum_in};
  assign w_sum     = (w_sum_ext[ACC_W] != w_sum_ext[ACC_W-1])
                   ? (w_sum_ext[ACC_W] ? SAT_MIN : SAT_MAX)
                   : w_sum_ext[ACC_W-1:0];

`ifdef PSUM_ACC_RELU_EN
  assign w_push_val = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_push_val = w_sum;
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < TILE; i++) begin
      if (w_beat && !io_bus.last_chanel && w_sel[i]) r_acc[i] <= w_sum;
    end
    if (w_wr) r_mem[r_wr_ptr] <= w_push_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_ev  <= '0;
    end else if (io_bus.start_conv) begin
      r_pos <= '0;
      r_ev  <= '0;
    end else if (w_beat) begin
      r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + POS_W'(1);
      r_ev  <= (r_ev & ~w_sel) | (io_bus.last_chanel ? '0 : w_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else if (io_bus.start_conv) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_push && w_full && !w_pop) r_ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_acc_done <= 1'b0;
    end else if (io_bus.start_conv) begin
      r_state    <= RUN;
      r_acc_done <= 1'b0;
    end else begin
      case (r_state)
        RUN: if (io_bus.end_conv) r_state <= DRAIN;
        DRAIN: begin
          if (w_empty && !w_push) begin
            r_state    <= DONE;
            r_acc_done <= 1'b1;
          end
        end
        DONE: begin
          if (w_push) begin
            r_state    <= DRAIN;
            r_acc_done <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign io_bus.ofm_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign io_bus.ofm_valid  = ~w_empty;
  assign io_bus.fifo_count = r_count;
  assign io_bus.ovf_err    = r_ovf_err;
  assign io_bus.acc_done   = r_acc_done;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (TILE=16, FIFO_DEPTH=16).
module tb_psum_accumulator;
  localparam int TILE = 16, PSUM_W = 16, ACC_W = 24, FIFO_DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  psum_accumulator_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  psum_accumulator #(.TILE(TILE), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic signed [PSUM_W-1:0] d);
    bus.p_valid     = v;
    bus.last_chanel = l;
    bus.psum_in     = d;
  endtask

  task automatic start_pulse();
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, longint'(bus.ofm_valid), 0);
    check_val({tag, "_count"}, longint'(bus.fifo_count), 0);
    check_val({tag, "_ovf"},   longint'(bus.ovf_err), 0);
    check_val({tag, "_done"},  longint'(bus.acc_done), 0);
    check_val({tag, "_data"},  longint'(bus.ofm_data), 0);
  endtask

  // Pass 1 writes pos+1, pass 2 adds 10 on the last channel: outputs 11..26
  task automatic run_two_pass(input string tag);
    bus.ofm_ready = 1'b1;
    for (int p = 0; p < TILE; p++) begin
      drive(1'b1, 1'b0, PSUM_W'(p + 1));
      step();
    end
    for (int p = 0; p < TILE; p++) begin
      drive(1'b1, 1'b1, 16'sd10);
      step();
      check_val({tag, "_valid"}, longint'(bus.ofm_valid), 1);
      check_val({tag, "_data"},  longint'(bus.ofm_data), longint'(11 + p));
    end
    drive(1'b0, 1'b0, '0);
    step();
    check_val({tag, "_count_end"}, longint'(bus.fifo_count), 0);
    check_val({tag, "_ovf_end"},   longint'(bus.ovf_err), 0);
  endtask

  task automatic drain_expect(input string tag, input int first, input int n);
    bus.ofm_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_valid"}, longint'(bus.ofm_valid), 1);
      check_val({tag, "_data"},  longint'(bus.ofm_data), longint'(first + i));
      step();
    end
    check_val({tag, "_empty"}, longint'(bus.fifo_count), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start_conv = 1'b0;
    bus.end_conv   = 1'b0;
    bus.ofm_ready  = 1'b0;
    drive(1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    step();

    run_two_pass("two_pass");

    // Saturation: 300 passes of +32767 to every position, then a last beat
    start_pulse();
    bus.ofm_ready = 1'b1;
    for (int k = 0; k < 300 * TILE; k++) begin
      drive(1'b1, 1'b0, 16'sd32767);
      step();
    end
    for (int p = 0; p < TILE; p++) begin
      drive(1'b1, 1'b1, 16'sd32767);
      step();
      check_val("sat_data", longint'(bus.ofm_data), 8388607);
    end
    drive(1'b0, 1'b0, '0);
    step();

    // Backpressure: 17 results into a 16-deep FIFO
    start_pulse();
    bus.ofm_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, PSUM_W'(100 + i));
      step();
    end
    drive(1'b0, 1'b0, '0);
    check_val("ovf_count", longint'(bus.fifo_count), 16);
    check_val("ovf_flag",  longint'(bus.ovf_err), 1);
    drain_expect("ovf_drain", 100, 16);

    // Full FIFO with simultaneous push and pop
    start_pulse();
    bus.ofm_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, PSUM_W'(200 + i));
      step();
    end
    check_val("full_count_pre", longint'(bus.fifo_count), 16);
    drive(1'b1, 1'b1, 16'sd216);
    bus.ofm_ready = 1'b1;
    step();
    drive(1'b0, 1'b0, '0);
    bus.ofm_ready = 1'b0;
    check_val("full_count_pp", longint'(bus.fifo_count), 16);
    check_val("full_ovf_pp",   longint'(bus.ovf_err), 0);
    drain_expect("full_drain", 201, 16);

    // End handling: 3 queued, end_conv, drain one per cycle
    start_pulse();
    bus.ofm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, PSUM_W'(i + 1));
      step();
    end
    drive(1'b0, 1'b0, '0);
    bus.end_conv = 1'b1;
    step();
    bus.end_conv = 1'b0;
    check_val("end_done_q", longint'(bus.acc_done), 0);
    bus.ofm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("end_head", longint'(bus.ofm_data), longint'(i + 1));
      step();
      check_val("end_count", longint'(bus.fifo_count), longint'(2 - i));
      check_val("end_done_drain", longint'(bus.acc_done), 0);
    end
    step();
    check_val("end_done_rise", longint'(bus.acc_done), 1);
    step();
    check_val("end_done_hold", longint'(bus.acc_done), 1);
    bus.ofm_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, PSUM_W'(i));
      step();
      if (i == 0) check_val("end_done_push", longint'(bus.acc_done), 0);
    end
    drive(1'b0, 1'b0, '0);
    check_val("end_ovf_set", longint'(bus.ovf_err), 1);
    start_pulse();
    check_idle("end_start");

    // Reset in the middle of pass 1, then a clean run
    bus.ofm_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 1'b0, 16'sd1000);
      step();
    end
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    step();
    rst_n = 1'b1;
    step();
    run_two_pass("after_reset");

    // Negative sum: -2 then -3 on the last channel
    start_pulse();
    bus.ofm_ready = 1'b1;
    for (int p = 0; p < TILE; p++) begin
      drive(1'b1, 1'b0, -16'sd2);
      step();
    end
    for (int p = 0; p < TILE; p++) begin
      drive(1'b1, 1'b1, -16'sd3);
      step();
`ifdef PSUM_ACC_RELU_EN
      check_val("neg_relu", longint'(bus.ofm_data), 0);
`else
      check_val("neg_sum", longint'(bus.ofm_data), -5);
`endif
    end
    drive(1'b0, 1'b0, '0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
